uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 124 ++++++++++++
 tb/tb_uart_rx_param.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver with a synchronised line, mid-bit sampling, a one-word output register and sticky overrun.
module uart_rx_param #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serialIn,
    input  logic                 rxReady,
    input  logic                 errClear,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    output logic                 frameErr,
    output logic                 parityErr,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CPB  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = ($clog2(CPB) > 0) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] RELOAD  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
    localparam logic [3:0]    LAST_D  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_S  = 4'(STOP_BITS - 1);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT} state_t;
    state_t               state, state_n;
    logic                 sync1, rx_s;
    logic [CW-1:0]        cnt, cnt_n;
    logic [3:0]           idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 ferr, ferr_n, perr, perr_n, done, done_n, tick;
    logic                 load, drop;
    assign tick = cnt == '0;
    assign busy = state != S_IDLE;
    // A finished word replaces the held one only if the slot is empty or being accepted this cycle.
    assign load = done && (!rxValid || rxReady);
    assign drop = done && rxValid && !rxReady;
    always_comb begin
        state_n = state;
        cnt_n   = tick ? cnt : cnt - CW'(1);
        idx_n   = idx;
        shreg_n = shreg;
        ferr_n  = ferr;
        perr_n  = perr;
        done_n  = 1'b0;
        case (state)
            S_IDLE: if (!rx_s) begin
                state_n = S_START;
                cnt_n   = HALF_LD;
                ferr_n  = 1'b0;
                perr_n  = 1'b0;
            end
            S_START: if (tick) begin
                state_n = rx_s ? S_IDLE : S_DATA;
                cnt_n   = rx_s ? '0 : RELOAD;
                idx_n   = '0;
            end
            S_DATA: if (tick) begin
                shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                cnt_n   = RELOAD;
                idx_n   = (idx == LAST_D) ? '0 : idx + 4'd1;
                if (idx == LAST_D) state_n = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: if (tick) begin
                perr_n  = ((^shreg) ^ rx_s) != (PARITY == 1);
                state_n = S_STOP;
                cnt_n   = RELOAD;
            end
            S_STOP: if (tick) begin
                ferr_n = ferr | !rx_s;
                idx_n  = idx + 4'd1;
                cnt_n  = RELOAD;
                if (idx == LAST_S) begin
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = rx_s ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: if (rx_s) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            ferr      <= 1'b0;
            perr      <= 1'b0;
            done      <= 1'b0;
            rxData    <= '0;
            rxValid   <= 1'b0;
            frameErr  <= 1'b0;
            parityErr <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync1 <= serialIn;
            rx_s  <= sync1;
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            ferr  <= ferr_n;
            perr  <= perr_n;
            done  <= done_n;
            if (load) begin
                rxData    <= shreg;
                frameErr  <= ferr;
                parityErr <= perr;
                rxValid   <= 1'b1;
            end else if (rxValid && rxReady) begin
                rxValid <= 1'b0;
            end
            if (drop) overrun <= 1'b1;
            else if (errClear) overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and random frames into a no-parity and an even-parity receiver, checked against frame-level expectations.
module tb_uart_rx_param;
    localparam int CLK_HZ = 21_000_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = 210;
    localparam int HALF   = 105;
    logic       clk = 1'b0, reset = 1'b1;
    logic       s0 = 1'b1, s1 = 1'b1, rdy0 = 1'b0, rdy1 = 1'b0, clr0 = 1'b0, clr1 = 1'b0;
    logic [7:0] d0, d1;
    logic       v0, fe0, pe0, ov0, b0, v1, fe1, pe1, ov1, b1;
    int         checks = 0, errors = 0;
    int         cyc = 0, n0 = 0, n1 = 0, rise0 = 0;
    logic       v0n = 1'b0, v1n = 1'b0;
    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u0 (
        .clk(clk), .reset(reset), .serialIn(s0), .rxReady(rdy0), .errClear(clr0),
        .rxData(d0), .rxValid(v0), .frameErr(fe0), .parityErr(pe0), .overrun(ov0), .busy(b0));
    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(2)) u1 (
        .clk(clk), .reset(reset), .serialIn(s1), .rxReady(rdy1), .errClear(clr1),
        .rxData(d1), .rxValid(v1), .frameErr(fe1), .parityErr(pe1), .overrun(ov1), .busy(b1));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (v0 && !v0n) begin
            n0 = n0 + 1;
            rise0 = cyc;
        end
        if (v1 && !v1n) n1 = n1 + 1;
        v0n = v0;
        v1n = v1;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic send(input int i, input logic [15:0] bits, input int n);
        for (int k = 0; k < n; k++) begin
            if (i == 0) s0 = bits[k];
            else s1 = bits[k];
            tick(CPB);
        end
    endtask
    task automatic frame0(input logic [7:0] d, input logic stop);
        send(0, {7'b0, stop, d, 1'b0}, 10);
    endtask
    task automatic frame1(input logic [7:0] d, input logic par, input logic stop);
        send(1, {6'b0, stop, par, d, 1'b0}, 11);
    endtask
    task automatic idle(input int i, input int n);
        if (i == 0) s0 = 1'b1;
        else s1 = 1'b1;
        tick(n);
    endtask
    task automatic accept(input int i);
        if (i == 0) rdy0 = 1'b1;
        else rdy1 = 1'b1;
        tick(1);
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        chk(i == 0 ? "accept0_valid" : "accept1_valid", i == 0 ? v0 : v1, 0);
    endtask
    task automatic word0(input string tag, input logic [7:0] d, input logic fe);
        chk({tag, "_valid"}, v0, 1);
        chk({tag, "_data"}, d0, d);
        chk({tag, "_ferr"}, fe0, fe);
        chk({tag, "_perr"}, pe0, 0);
    endtask
    task automatic word1(input string tag, input logic [7:0] d, input logic fe, input logic pe);
        chk({tag, "_valid"}, v1, 1);
        chk({tag, "_data"}, d1, d);
        chk({tag, "_ferr"}, fe1, fe);
        chk({tag, "_perr"}, pe1, pe);
    endtask
    initial begin
        int s, snap, lat;
        logic [7:0] d;
        logic stop, par, pe_e;
        @(posedge clk);
        #1;
        tick(5);
        chk("rst_data", {d1, d0}, 0);
        chk("rst_flags", {v0, fe0, pe0, ov0, b0, v1, fe1, pe1, ov1, b1}, 0);
        reset = 1'b0;
        tick(5);
        chk("idle_busy", {b0, b1}, 0);
        s = cyc;
        frame0(8'h55, 1'b1);
        word0("f55", 8'h55, 1'b0);
        chk("f55_ovr", ov0, 0);
        lat = rise0 - s;
        chk("f55_latency_ok", 32'(lat >= HALF + 9 * CPB + 2 && lat <= HALF + 9 * CPB + 4), 1);
        accept(0);
        idle(1, 7);
        frame1(8'hA3, 1'b1, 1'b1);
        word1("pA3_bad", 8'hA3, 1'b0, 1'b1);
        accept(1);
        idle(1, 3);
        frame1(8'hA3, 1'b0, 1'b1);
        word1("pA3_good", 8'hA3, 1'b0, 1'b0);
        accept(1);
        idle(0, 11);
        snap = n0;
        frame0(8'h3C, 1'b0);
        word0("brk3C", 8'h3C, 1'b1);
        chk("brk_busy_a", b0, 1);
        tick(10 * CPB);
        chk("brk_busy_b", b0, 1);
        tick(10 * CPB);
        chk("brk_busy_c", b0, 1);
        idle(0, 4);
        chk("brk_busy_end", b0, 0);
        chk("brk_one_valid", n0 - snap, 1);
        accept(0);
        snap = n0;
        s0 = 1'b0;
        tick(100);
        idle(0, CPB);
        chk("glitch_busy", b0, 0);
        chk("glitch_valid", v0, 0);
        chk("glitch_no_word", n0 - snap, 0);
        frame0(8'h12, 1'b1);
        word0("f12", 8'h12, 1'b0);
        accept(0);
        for (int r = 0; r < 6; r++) begin
            d = 8'($urandom);
            stop = $urandom_range(0, 3) != 0;
            idle(0, $urandom_range(2, 40));
            frame0(d, stop);
            word0("rnd0", d, !stop);
            accept(0);
        end
        for (int r = 0; r < 6; r++) begin
            d = 8'($urandom);
            par = 1'($urandom_range(0, 1));
            stop = $urandom_range(0, 3) != 0;
            pe_e = int'(par) != $countones(d) % 2;
            idle(1, $urandom_range(2, 40));
            frame1(d, par, stop);
            word1("rnd1", d, !stop, pe_e);
            accept(1);
        end
        idle(1, 5);
        idle(0, 5);
        frame0(8'h11, 1'b1);
        word0("o11", 8'h11, 1'b0);
        frame0(8'h22, 1'b1);
        word0("o22_held", 8'h11, 1'b0);
        chk("o22_ovr", ov0, 1);
        clr0 = 1'b1;
        tick(1);
        clr0 = 1'b0;
        chk("ovr_cleared", ov0, 0);
        accept(0);
        frame0(8'h33, 1'b1);
        frame0(8'h44, 1'b1);
        chk("o44_ovr", ov0, 1);
        chk("o44_data", d0, 8'h33);
        send(0, 16'b1110, 4);
        reset = 1'b1;
        tick(3);
        chk("midrst_data", d0, 0);
        chk("midrst_flags", {v0, fe0, pe0, ov0, b0}, 0);
        reset = 1'b0;
        snap = n0;
        idle(0, 6 * CPB);
        chk("postrst_valid", v0, 0);
        frame0(8'h0F, 1'b1);
        word0("f0F", 8'h0F, 1'b0);
        chk("postrst_one_valid", n0 - snap, 1);
        accept(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
